// File: rtl/cgra_data_bus_arbiter_pkg.sv
// Shared types and constants for the CGRA data bus arbiter slice.
// Sizing lives here so the interface, top and ID FIFO agree on every width.
package cgra_data_bus_arbiter_pkg;

    localparam int N_COL      = 4;
    localparam int MP         = 2;
    localparam int MAX_OUTSTD = 2;
    localparam int ADD_W      = 32;
    localparam int DATA_W     = 32;
    localparam int BE_W       = 4;
    localparam int N_COL_LOG2 = (N_COL > 1) ? $clog2(N_COL) : 1;

    typedef logic [N_COL_LOG2-1:0] col_id_t;

    typedef struct packed {
        logic [ADD_W-1:0]  add;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic              we;
    } obi_req_t;

    // Column index plus one, wrapping at N_COL (N_COL need not be a power of two)
    function automatic col_id_t next_col(input col_id_t c);
        return (c == col_id_t'(N_COL - 1)) ? '0 : c + col_id_t'(1);
    endfunction

endpackage

// File: rtl/cgra_data_bus_arbiter_if.sv
// Column-side and memory-side bus bundle of the data bus arbiter.
// master is the arbiter's view; slave is the column handlers plus memory.
interface cgra_data_bus_arbiter_if;
    import cgra_data_bus_arbiter_pkg::*;

    logic [N_COL-1:0]             col_req_i;
    logic [N_COL-1:0]             col_wen_i;
    logic [N_COL-1:0][ADD_W-1:0]  col_add_i;
    logic [N_COL-1:0][DATA_W-1:0] col_wdata_i;
    logic [N_COL-1:0][BE_W-1:0]   col_be_i;
    logic [N_COL-1:0]             col_gnt_o;
    logic [N_COL-1:0]             col_rvalid_o;
    logic [N_COL-1:0][DATA_W-1:0] col_rdata_o;

    logic [MP-1:0]                mem_req_o;
    logic [MP-1:0]                mem_we_o;
    logic [MP-1:0][ADD_W-1:0]     mem_add_o;
    logic [MP-1:0][DATA_W-1:0]    mem_wdata_o;
    logic [MP-1:0][BE_W-1:0]      mem_be_o;
    logic [MP-1:0]                mem_gnt_i;
    logic [MP-1:0]                mem_rvalid_i;
    logic [MP-1:0][DATA_W-1:0]    mem_rdata_i;

    modport master (
        input  col_req_i, col_wen_i, col_add_i, col_wdata_i, col_be_i,
        output col_gnt_o, col_rvalid_o, col_rdata_o,
        output mem_req_o, mem_we_o, mem_add_o, mem_wdata_o, mem_be_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        output col_req_i, col_wen_i, col_add_i, col_wdata_i, col_be_i,
        input  col_gnt_o, col_rvalid_o, col_rdata_o,
        input  mem_req_o, mem_we_o, mem_add_o, mem_wdata_o, mem_be_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/cgra_arb_id_fifo.sv
// Per-port FIFO of issuing column IDs; the head is the column owed the next rvalid.
// Push and pop in the same cycle are legal even when full.
module cgra_arb_id_fifo
    import cgra_data_bus_arbiter_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    push_i,
    input  col_id_t id_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output col_id_t head_o
);

    localparam int PTR_W = (MAX_OUTSTD > 1) ? $clog2(MAX_OUTSTD) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTD + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    col_id_t mem_reg [MAX_OUTSTD];
    ptr_t    wr_ptr_reg, wr_ptr_next;
    ptr_t    rd_ptr_reg, rd_ptr_next;
    cnt_t    cnt_reg, cnt_next;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(MAX_OUTSTD - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    always_comb begin
        wr_ptr_next = push_i ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = pop_i  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        cnt_next    = cnt_reg;
        if (push_i && !pop_i) begin
            cnt_next = cnt_reg + cnt_t'(1);
        end else if (pop_i && !push_i) begin
            cnt_next = cnt_reg - cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_reg[wr_ptr_reg] <= id_i;
        end
    end

    assign head_o  = mem_reg[rd_ptr_reg];
    assign full_o  = (cnt_reg == cnt_t'(MAX_OUTSTD));
    assign empty_o = (cnt_reg == '0);

endmodule

// File: rtl/cgra_data_bus_arbiter.sv
// Round-robin arbiter of N_COL column OBI requests onto MP memory ports with
// per-port ID FIFOs for response routing. Optional macro: CGRA_ARB_PERF_CNT_EN.
module cgra_data_bus_arbiter
    import cgra_data_bus_arbiter_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
`ifdef CGRA_ARB_PERF_CNT_EN
    input  logic                   cnt_clr_i,
    output logic [N_COL-1:0][31:0] conflict_cnt_o,
`endif
    cgra_data_bus_arbiter_if.master bus
);

    logic [N_COL-1:0]             out_flag_reg, out_flag_next;
    col_id_t                      rr_ptr_reg, rr_ptr_next;
    logic [N_COL-1:0]             eligible;
    logic [N_COL-1:0]             col_gnt;
    logic [N_COL-1:0]             col_rvalid;
    logic [N_COL-1:0][DATA_W-1:0] col_rdata;
    obi_req_t                     col_req_s [N_COL];

    logic [MP-1:0]                port_valid;
    logic [MP-1:0]                port_hs;
    logic [MP-1:0]                fifo_full, fifo_empty, fifo_pop;
    col_id_t                      win_id    [MP];
    col_id_t                      fifo_head [MP];
    obi_req_t                     port_req  [MP];

    genvar gi, gj;

    // A column whose response returns this cycle may be re-granted at once
    for (gi = 0; gi < N_COL; gi++) begin : g_col
        assign col_req_s[gi] = '{add:   bus.col_add_i[gi],
                                 wdata: bus.col_wdata_i[gi],
                                 be:    bus.col_be_i[gi],
                                 we:    ~bus.col_wen_i[gi]};
        assign eligible[gi]  = bus.col_req_i[gi] & (~out_flag_reg[gi] | col_rvalid[gi]);
    end

    always_comb begin
        col_rvalid = '0;
        col_rdata  = '0;
        for (int p = 0; p < MP; p++) begin
            if (fifo_pop[p]) begin
                col_rvalid[fifo_head[p]] = 1'b1;
                col_rdata[fifo_head[p]]  = bus.mem_rdata_i[p];
            end
        end
    end

    always_comb begin
        logic [N_COL-1:0] taken;
        col_id_t          cid;
        logic             found;
        taken      = '0;
        port_valid = '0;
        for (int p = 0; p < MP; p++) begin
            win_id[p] = '0;
            cid       = rr_ptr_reg;
            found     = 1'b0;
            if (!fifo_full[p] || bus.mem_rvalid_i[p]) begin
                for (int k = 0; k < N_COL; k++) begin
                    if (!found && eligible[cid] && !taken[cid]) begin
                        found     = 1'b1;
                        win_id[p] = cid;
                    end
                    cid = next_col(cid);
                end
            end
            if (found) begin
                taken[win_id[p]] = 1'b1;
            end
            port_valid[p] = found;
        end
    end

    always_comb begin
        col_gnt = '0;
        for (int p = 0; p < MP; p++) begin
            if (port_valid[p]) begin
                col_gnt[win_id[p]] = bus.mem_gnt_i[p];
            end
        end
    end

    // Grant beats response: a column popped and re-granted stays outstanding
    always_comb begin
        out_flag_next = out_flag_reg;
        rr_ptr_next   = rr_ptr_reg;
        for (int p = 0; p < MP; p++) begin
            if (fifo_pop[p]) begin
                out_flag_next[fifo_head[p]] = 1'b0;
            end
        end
        for (int p = 0; p < MP; p++) begin
            if (port_hs[p]) begin
                out_flag_next[win_id[p]] = 1'b1;
                rr_ptr_next              = next_col(win_id[p]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_flag_reg <= '0;
            rr_ptr_reg   <= '0;
        end else begin
            out_flag_reg <= out_flag_next;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

    // Outputs are forced low while reset is asserted, without waiting for a clock
    assign bus.col_gnt_o    = rst_ni ? col_gnt    : '0;
    assign bus.col_rvalid_o = rst_ni ? col_rvalid : '0;
    assign bus.col_rdata_o  = rst_ni ? col_rdata  : '0;

    for (gi = 0; gi < MP; gi++) begin : g_port
        assign port_req[gi]        = port_valid[gi] ? col_req_s[win_id[gi]] : '0;
        assign port_hs[gi]         = port_valid[gi] & bus.mem_gnt_i[gi];
        assign fifo_pop[gi]        = bus.mem_rvalid_i[gi] & ~fifo_empty[gi];

        assign bus.mem_req_o[gi]   = rst_ni & port_valid[gi];
        assign bus.mem_we_o[gi]    = rst_ni & port_req[gi].we;
        assign bus.mem_add_o[gi]   = rst_ni ? port_req[gi].add   : '0;
        assign bus.mem_wdata_o[gi] = rst_ni ? port_req[gi].wdata : '0;
        assign bus.mem_be_o[gi]    = rst_ni ? port_req[gi].be    : '0;

        cgra_arb_id_fifo u_id_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (port_hs[gi]),
            .id_i    (win_id[gi]),
            .pop_i   (fifo_pop[gi]),
            .full_o  (fifo_full[gi]),
            .empty_o (fifo_empty[gi]),
            .head_o  (fifo_head[gi])
        );

        a_rvalid_tracked: assert property (@(posedge clk_i) disable iff (!rst_ni)
            bus.mem_rvalid_i[gi] |-> !fifo_empty[gi]);

        for (gj = gi + 1; gj < MP; gj++) begin : g_pair
            a_single_return: assert property (@(posedge clk_i) disable iff (!rst_ni)
                !(fifo_pop[gi] && fifo_pop[gj] && (fifo_head[gi] == fifo_head[gj])));
        end
    end

`ifdef CGRA_ARB_PERF_CNT_EN
    logic [31:0] cnt_reg [N_COL];

    for (gi = 0; gi < N_COL; gi++) begin : g_perf
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_reg[gi] <= '0;
            end else if (cnt_clr_i) begin
                cnt_reg[gi] <= '0;
            end else if (bus.col_req_i[gi] && !col_gnt[gi] && (cnt_reg[gi] != '1)) begin
                cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
            end
        end
        assign conflict_cnt_o[gi] = cnt_reg[gi];
    end
`endif

endmodule

// File: tb/tb_cgra_data_bus_arbiter.sv
// Directed bench for the data bus arbiter: a memory model answers each port in
// order and a per-column scoreboard checks that every response lands on its issuer.
module tb_cgra_data_bus_arbiter;
    import cgra_data_bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_ni;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] mem_q [MP][$];
    logic [31:0] exp_q [N_COL][$];

    always #5 clk = ~clk;

    cgra_data_bus_arbiter_if bus ();

`ifdef CGRA_ARB_PERF_CNT_EN
    logic                   cnt_clr;
    logic [N_COL-1:0][31:0] conflict_cnt;
`endif

    cgra_data_bus_arbiter dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
`ifdef CGRA_ARB_PERF_CNT_EN
        .cnt_clr_i      (cnt_clr),
        .conflict_cnt_o (conflict_cnt),
`endif
        .bus            (bus)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.mem_rvalid_i = '0;
        bus.mem_rdata_i  = '0;
    endtask

    task automatic set_addrs(input int s);
        for (int c = 0; c < N_COL; c++) begin
            bus.col_add_i[c]   = 32'h1000 + 32'(c) * 32'h100 + 32'(s) * 32'h10;
            bus.col_wdata_i[c] = ~bus.col_add_i[c];
            bus.col_be_i[c]    = 4'hF;
        end
    endtask

    task automatic respond(input int p);
        logic [31:0] a;
        if (mem_q[p].size() == 0) begin
            chk("resp_pending", 64'(mem_q[p].size()), 64'h1);
        end else begin
            a = mem_q[p].pop_front();
            bus.mem_rvalid_i[p] = 1'b1;
            bus.mem_rdata_i[p]  = data_of(a);
        end
    endtask

    task automatic clear_sb();
        for (int p = 0; p < MP; p++) mem_q[p].delete();
        for (int c = 0; c < N_COL; c++) exp_q[c].delete();
    endtask

    task automatic reset_dut();
        bus.col_req_i    = '0;
        bus.mem_rvalid_i = '0;
        #1 rst_ni = 1'b0;
        clear_sb();
        @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    // Memory model and column scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_ni) begin
            for (int c = 0; c < N_COL; c++) begin
                if (bus.col_rvalid_o[c]) begin
                    if (exp_q[c].size() == 0) begin
                        chk($sformatf("rv_expected_c%0d", c), 64'(exp_q[c].size()), 64'h1);
                    end else begin
                        $display("[TB] resp  col%0d rdata=0x%08h", c, bus.col_rdata_o[c]);
                        chk($sformatf("rdata_c%0d", c), 64'(bus.col_rdata_o[c]), 64'(exp_q[c].pop_front()));
                    end
                end else begin
                    chk($sformatf("rdata_idle_c%0d", c), 64'(bus.col_rdata_o[c]), 64'h0);
                end
            end
            for (int c = 0; c < N_COL; c++) begin
                if (bus.col_req_i[c] && bus.col_gnt_o[c]) begin
                    $display("[TB] grant col%0d add=0x%08h", c, bus.col_add_i[c]);
                    exp_q[c].push_back(data_of(bus.col_add_i[c]));
                end
            end
            for (int p = 0; p < MP; p++) begin
                if (bus.mem_req_o[p] && bus.mem_gnt_i[p]) mem_q[p].push_back(bus.mem_add_o[p]);
            end
        end
    end

    initial begin
        rst_ni           = 1'b1;
        bus.col_req_i    = '0;
        bus.col_wen_i    = '1;
        bus.mem_gnt_i    = '0;
        bus.mem_rvalid_i = '0;
        bus.mem_rdata_i  = '0;
        set_addrs(0);
`ifdef CGRA_ARB_PERF_CNT_EN
        cnt_clr = 1'b0;
`endif
        // Outputs held low during reset even with live requests
        #2 rst_ni = 1'b0;
        bus.col_req_i = '1;
        bus.mem_gnt_i = '1;
        @(negedge clk);
        chk("rst_mem_req", 64'(bus.mem_req_o), 64'h0);
        chk("rst_col_gnt", 64'(bus.col_gnt_o), 64'h0);
        chk("rst_mem_add0", 64'(bus.mem_add_o[0]), 64'h0);
        @(posedge clk);
        #1 bus.col_req_i = '0;
        rst_ni = 1'b1;

        // Single read on column 0
        set_addrs(1);
        bus.col_req_i = 4'b0001;
        @(negedge clk);
        chk("rd_col_gnt", 64'(bus.col_gnt_o), 64'h1);
        chk("rd_mem_req", 64'(bus.mem_req_o), 64'h1);
        chk("rd_mem_add0", 64'(bus.mem_add_o[0]), 64'h1010);
        chk("rd_mem_we0", 64'(bus.mem_we_o[0]), 64'h0);
        tick();
        bus.col_req_i = '0;
        @(negedge clk);
        chk("rd_idle_gnt", 64'(bus.col_gnt_o), 64'h0);
        tick();
        respond(0);
        @(negedge clk);
        chk("rd_rvalid", 64'(bus.col_rvalid_o), 64'h1);
        tick();

        // rr_ptr=1: col3 write wins port 0, col0 wraps onto port 1
        set_addrs(2);
        bus.col_wen_i = 4'b0111;
        bus.col_req_i = 4'b1001;
        @(negedge clk);
        chk("wr_col_gnt", 64'(bus.col_gnt_o), 64'h9);
        chk("wr_mem_we", 64'(bus.mem_we_o), 64'h1);
        chk("wr_mem_add0", 64'(bus.mem_add_o[0]), 64'h1320);
        chk("wr_mem_wdata0", 64'(bus.mem_wdata_o[0]), 64'hFFFF_ECDF);
        chk("wr_mem_add1", 64'(bus.mem_add_o[1]), 64'h1020);
        tick();
        bus.col_req_i = '0;
        bus.col_wen_i = '1;
        respond(1);
        @(negedge clk);
        chk("ooo_rvalid_p1", 64'(bus.col_rvalid_o), 64'h1);
        tick();
        respond(0);
        @(negedge clk);
        chk("ooo_rvalid_p0", 64'(bus.col_rvalid_o), 64'h8);
        tick();

        // Contention: four readers, two ports
        reset_dut();
        set_addrs(3);
        bus.col_req_i = 4'b1111;
        @(negedge clk);
        chk("cont_gnt_c1", 64'(bus.col_gnt_o), 64'h3);
        chk("cont_add0_c1", 64'(bus.mem_add_o[0]), 64'h1030);
        chk("cont_add1_c1", 64'(bus.mem_add_o[1]), 64'h1130);
        tick();
        @(negedge clk);
        chk("cont_gnt_c2", 64'(bus.col_gnt_o), 64'hC);
        chk("cont_add0_c2", 64'(bus.mem_add_o[0]), 64'h1230);
        tick();
        @(negedge clk);
        chk("cont_blocked_req", 64'(bus.mem_req_o), 64'h0);
        chk("cont_blocked_gnt", 64'(bus.col_gnt_o), 64'h0);
        tick();
        // Back-to-back: col1 returns on port 1 and is re-granted the same cycle
        respond(1);
        @(negedge clk);
        chk("b2b_rvalid", 64'(bus.col_rvalid_o), 64'h2);
        chk("b2b_gnt", 64'(bus.col_gnt_o), 64'h2);
        chk("b2b_mem_req", 64'(bus.mem_req_o), 64'h2);
        tick();
        bus.col_req_i = '0;
        respond(0);
        @(negedge clk);
        chk("drain_rv_a", 64'(bus.col_rvalid_o), 64'h1);
        tick();
        respond(0);
        @(negedge clk);
        chk("drain_rv_b", 64'(bus.col_rvalid_o), 64'h4);
        tick();
        respond(1);
        @(negedge clk);
        chk("drain_rv_c", 64'(bus.col_rvalid_o), 64'h8);
        tick();
        respond(1);
        @(negedge clk);
        chk("drain_rv_d", 64'(bus.col_rvalid_o), 64'h2);
        tick();
        bus.col_req_i = 4'b0001;
        @(negedge clk);
        chk("flag_cleared_gnt", 64'(bus.col_gnt_o), 64'h1);
        tick();
        bus.col_req_i = '0;
        respond(0);
        @(negedge clk);
        chk("flag_cleared_rv", 64'(bus.col_rvalid_o), 64'h1);
        tick();

        // Full FIFO on port 0 (port 1 never grants)
        reset_dut();
        set_addrs(4);
        bus.mem_gnt_i = 2'b01;
        bus.col_req_i = 4'b1111;
        @(negedge clk);
        chk("full_gnt_c1", 64'(bus.col_gnt_o), 64'h1);
        chk("full_req_c1", 64'(bus.mem_req_o), 64'h3);
        tick();
        @(negedge clk);
        chk("full_gnt_c2", 64'(bus.col_gnt_o), 64'h2);
        tick();
        @(negedge clk);
        chk("full_req_c3", 64'(bus.mem_req_o), 64'h2);
        chk("full_gnt_c3", 64'(bus.col_gnt_o), 64'h0);
        tick();
        respond(0);
        @(negedge clk);
        chk("full_pop_gnt", 64'(bus.col_gnt_o), 64'h4);
        chk("full_pop_rv", 64'(bus.col_rvalid_o), 64'h1);
        chk("full_pop_add0", 64'(bus.mem_add_o[0]), 64'h1240);
        tick();
        bus.col_req_i = '0;
        respond(0);
        @(negedge clk);
        chk("full_drain_a", 64'(bus.col_rvalid_o), 64'h2);
        tick();
        respond(0);
        @(negedge clk);
        chk("full_drain_b", 64'(bus.col_rvalid_o), 64'h4);
        tick();

        // Async reset with three transactions outstanding
        reset_dut();
        set_addrs(5);
        bus.mem_gnt_i = 2'b11;
        bus.col_req_i = 4'b0111;
        @(negedge clk);
        chk("ar_gnt_c1", 64'(bus.col_gnt_o), 64'h3);
        tick();
        @(negedge clk);
        chk("ar_gnt_c2", 64'(bus.col_gnt_o), 64'h4);
        tick();
        bus.col_req_i = 4'b1111;
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_mem_req", 64'(bus.mem_req_o), 64'h0);
        chk("ar_col_gnt", 64'(bus.col_gnt_o), 64'h0);
        chk("ar_col_rvalid", 64'(bus.col_rvalid_o), 64'h0);
        chk("ar_mem_add1", 64'(bus.mem_add_o[1]), 64'h0);
        clear_sb();
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        chk("ar_post_gnt", 64'(bus.col_gnt_o), 64'h3);
        chk("ar_post_add0", 64'(bus.mem_add_o[0]), 64'h1050);
        tick();
        bus.col_req_i = '0;
        respond(0);
        @(negedge clk);
        chk("ar_drain_a", 64'(bus.col_rvalid_o), 64'h1);
        tick();
        respond(1);
        @(negedge clk);
        chk("ar_drain_b", 64'(bus.col_rvalid_o), 64'h2);
        tick();

`ifdef CGRA_ARB_PERF_CNT_EN
        reset_dut();
        @(negedge clk);
        chk("perf_rst_cnt0", 64'(conflict_cnt[0]), 64'h0);
        bus.mem_gnt_i = 2'b00;
        bus.col_req_i = 4'b0001;
        repeat (5) tick();
        @(negedge clk);
        chk("perf_cnt0", 64'(conflict_cnt[0]), 64'h5);
        chk("perf_cnt1", 64'(conflict_cnt[1]), 64'h0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("perf_clr_cnt0", 64'(conflict_cnt[0]), 64'h0);
        bus.col_req_i = '0;
        bus.mem_gnt_i = 2'b11;
        tick();
`endif

        for (int c = 0; c < N_COL; c++) chk($sformatf("sb_left_c%0d", c), 64'(exp_q[c].size()), 64'h0);
        for (int p = 0; p < MP; p++) chk($sformatf("mem_left_p%0d", p), 64'(mem_q[p].size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
